sfp_sum_tx: RTL and testbench

Transmit side of the inter-core SFP partial-sum link in the dual-core fullchip. Each core's SFP produces a `bw_psum+4`-bit sum that the peer core needs for softmax normalisation. The peer runs on an unrelated clock and samples the link through its own two-flop synchroniser. This block holds the sum stable on the link and signals it with a two-phase (toggle) request. It waits for the peer's toggle acknowledge, synchronised locally, before changing the data, and buffers one further sum while a transfer is in flight.

---
 rtl/sfp_sum_tx.sv | 141 ++++++++++++++
 tb/tb_sfp_sum_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_sum_tx.sv
// sfp_sum_tx: transmit side of the inter-core SFP partial-sum link.
// Holds one sum stable on tx_data and signals it with a two-phase toggle
// on tx_req. The peer's toggle acknowledge is synchronised locally through
// two flops. One further sum can be buffered while a transfer is open.
module sfp_sum_tx #(
    parameter int bw      = 8,
    parameter int bw_psum = 2 * bw + 4,
    parameter int sw      = bw_psum + 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [sw-1:0] sum_in,
    input  logic          sum_valid,
    output logic          sum_ready,
    output logic [sw-1:0] tx_data,
    output logic          tx_req,
    input  logic          rx_ack,
    output logic          busy,
    output logic          xfer_done,
    output logic [7:0]    xfer_cnt,
    output logic          drop_err
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [sw-1:0]   tx_data_q, tx_data_d;
    logic            tx_req_q, tx_req_d;
    logic            ack_s1_q, ack_s2_q;
    logic [sw-1:0]   pend_q, pend_d;
    logic            pend_v_q, pend_v_d;
    logic            xfer_done_q, xfer_done_d;
    logic [7:0]      xfer_cnt_q, xfer_cnt_d;
    logic            drop_err_q, drop_err_d;
    logic            complete_s;

    // A transfer is finished once the synchronised ack has caught up with
    // the request toggle; in IDLE the two are equal but meaningless.
    assign complete_s = (state_q == ST_WAIT_ACK) && (ack_s2_q == tx_req_q);

    // Two-flop synchroniser for the peer's asynchronous acknowledge toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_s1_q <= 1'b0;
            ack_s2_q <= 1'b0;
        end else begin
            ack_s1_q <= rx_ack;
            ack_s2_q <= ack_s1_q;
        end
    end

    // Next-state logic: launch, buffer, complete and drop decisions.
    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_req_d    = tx_req_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        xfer_done_d = 1'b0;
        xfer_cnt_d  = xfer_cnt_q;
        // The buffer slot is full, so any offered sum is lost.
        drop_err_d  = drop_err_q | (sum_valid & pend_v_q);

        case (state_q)
            ST_IDLE: begin
                if (sum_valid) begin
                    tx_data_d = sum_in;
                    tx_req_d  = ~tx_req_q;
                    state_d   = ST_WAIT_ACK;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (complete_s) begin
                    xfer_done_d = 1'b1;
                    xfer_cnt_d  = xfer_cnt_q + 8'd1;
                    if (pend_v_q) begin
                        // Buffered sum goes first to keep acceptance order.
                        tx_data_d = pend_q;
                        tx_req_d  = ~tx_req_q;
                        pend_v_d  = 1'b0;
                        state_d   = ST_WAIT_ACK;
                    end else if (sum_valid) begin
                        // Back-to-back launch with no IDLE bubble.
                        tx_data_d = sum_in;
                        tx_req_d  = ~tx_req_q;
                        state_d   = ST_WAIT_ACK;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end else begin
                    if (sum_valid && !pend_v_q) begin
                        pend_d   = sum_in;
                        pend_v_d = 1'b1;
                    end else begin
                        pend_v_d = pend_v_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, link and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            tx_data_q   <= {sw{1'b0}};
            tx_req_q    <= 1'b0;
            pend_q      <= {sw{1'b0}};
            pend_v_q    <= 1'b0;
            xfer_done_q <= 1'b0;
            xfer_cnt_q  <= 8'd0;
            drop_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_data_q   <= tx_data_d;
            tx_req_q    <= tx_req_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            xfer_done_q <= xfer_done_d;
            xfer_cnt_q  <= xfer_cnt_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign sum_ready = ~pend_v_q;
    assign tx_data   = tx_data_q;
    assign tx_req    = tx_req_q;
    assign busy      = (state_q == ST_WAIT_ACK);
    assign xfer_done = xfer_done_q;
    assign xfer_cnt  = xfer_cnt_q;
    assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_sfp_sum_tx.sv
// Self-checking bench for sfp_sum_tx: directed scenarios plus a randomised
// run against a peer/scoreboard model kept in the bench.
module tb_sfp_sum_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] sum_in;
    logic        sum_valid;
    logic        sum_ready;
    logic [23:0] tx_data;
    logic        tx_req;
    logic        rx_ack;
    logic        busy;
    logic        xfer_done;
    logic [7:0]  xfer_cnt;
    logic        drop_err;

    int errors = 0;
    int checks = 0;

    sfp_sum_tx dut (
        .clk       (clk),
        .reset     (reset),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .sum_ready (sum_ready),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .rx_ack    (rx_ack),
        .busy      (busy),
        .xfer_done (xfer_done),
        .xfer_cnt  (xfer_cnt),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    // Resets both sides of the link and returns on a negedge, inputs idle.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; sum_valid = 1'b0; sum_in = 24'h0; rx_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (tx_data !== 24'h0) begin errors++; $display("FAIL reset_tx_data: got %h want 000000", tx_data); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL reset_xfer_done: got %b want 0", xfer_done); end
        checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL reset_xfer_cnt: got %0d want 0", xfer_cnt); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err: got %b want 0", drop_err); end
        checks++; if (sum_ready !== 1'b1) begin errors++; $display("FAIL reset_sum_ready: got %b want 1", sum_ready); end
    endtask

    task automatic test_single();
        do_reset();
        sum_in = 24'h0ABCDE; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (tx_data !== 24'h0ABCDE) begin errors++; $display("FAIL single_data: got %h want 0abcde", tx_data); end
        checks++; if (tx_req !== 1'b1) begin errors++; $display("FAIL single_req: got %b want 1", tx_req); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        rx_ack = 1'b1;
        step();
        checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL single_done_early1: got %b want 0", xfer_done); end
        step();
        checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL single_done_early2: got %b want 0", xfer_done); end
        step();
        checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", xfer_done); end
        checks++; if (xfer_cnt !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", xfer_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: busy got %b want 0", busy); end
        step();
        checks++; if (xfer_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", xfer_done); end
    endtask

    task automatic test_buffered();
        do_reset();
        sum_in = 24'h000011; sum_valid = 1'b1;
        step();
        sum_in = 24'h000022; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (sum_ready !== 1'b0) begin errors++; $display("FAIL buf_ready_low: got %b want 0", sum_ready); end
        checks++; if (tx_data !== 24'h000011) begin errors++; $display("FAIL buf_hold_a: got %h want 000011", tx_data); end
        rx_ack = 1'b1;
        step(); step();
        checks++; if (tx_data !== 24'h000011) begin errors++; $display("FAIL buf_hold_a2: got %h want 000011", tx_data); end
        step();
        checks++; if (tx_data !== 24'h000022) begin errors++; $display("FAIL buf_launch_b: got %h want 000022", tx_data); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL buf_req_toggle: got %b want 0", tx_req); end
        checks++; if (sum_ready !== 1'b1) begin errors++; $display("FAIL buf_ready_high: got %b want 1", sum_ready); end
        checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL buf_done: got %b want 1", xfer_done); end
        rx_ack = 1'b0;
        step(); step(); step();
        checks++; if (xfer_cnt !== 8'd2) begin errors++; $display("FAIL buf_cnt: got %0d want 2", xfer_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL buf_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_drop();
        do_reset();
        sum_in = 24'h000011; sum_valid = 1'b1;
        step();
        sum_in = 24'h000022; sum_valid = 1'b1;
        step();
        sum_in = 24'h000033; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_set: got %b want 1", drop_err); end
        rx_ack = 1'b1;
        step(); step(); step();
        checks++; if (tx_data !== 24'h000022) begin errors++; $display("FAIL drop_seq_b: got %h want 000022", tx_data); end
        rx_ack = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy got %b want 0", busy); end
        checks++; if (tx_data !== 24'h000022) begin errors++; $display("FAIL drop_no_c: got %h want 000022", tx_data); end
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky: got %b want 1", drop_err); end
    endtask

    task automatic test_drop_on_completion();
        do_reset();
        sum_in = 24'h000044; sum_valid = 1'b1;
        step();
        sum_in = 24'h000055; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        rx_ack = 1'b1;
        step(); step();
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL dropc_clear: got %b want 0", drop_err); end
        sum_in = 24'h000066; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (tx_data !== 24'h000055) begin errors++; $display("FAIL dropc_pend_first: got %h want 000055", tx_data); end
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL dropc_set: got %b want 1", drop_err); end
        rx_ack = 1'b0;
        step(); step(); step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dropc_idle: busy got %b want 0", busy); end
        checks++; if (xfer_cnt !== 8'd2) begin errors++; $display("FAIL dropc_cnt: got %0d want 2", xfer_cnt); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        sum_in = 24'h000077; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        rx_ack = 1'b1;
        step(); step();
        sum_in = 24'h000088; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (tx_data !== 24'h000088) begin errors++; $display("FAIL same_data: got %h want 000088", tx_data); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL same_req: got %b want 0", tx_req); end
        checks++; if (xfer_done !== 1'b1) begin errors++; $display("FAIL same_done: got %b want 1", xfer_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL same_busy: got %b want 1", busy); end
        rx_ack = 1'b0;
        step(); step(); step();
        checks++; if (xfer_cnt !== 8'd2) begin errors++; $display("FAIL same_cnt: got %0d want 2", xfer_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL same_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sum_in = 24'h000099; sum_valid = 1'b1;
        step();
        sum_in = 24'h0000AA; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (busy !== 1'b1 || sum_ready !== 1'b0) begin errors++; $display("FAIL mid_pre: busy %b ready %b want 1 0", busy, sum_ready); end
        #2 reset = 1'b1; rx_ack = 1'b0;
        #1;
        checks++; if (tx_data !== 24'h0 || tx_req !== 1'b0) begin errors++; $display("FAIL mid_link: data %h req %b want 000000 0", tx_data, tx_req); end
        checks++; if (busy !== 1'b0 || sum_ready !== 1'b1) begin errors++; $display("FAIL mid_state: busy %b ready %b want 0 1", busy, sum_ready); end
        checks++; if (xfer_cnt !== 8'd0 || drop_err !== 1'b0 || xfer_done !== 1'b0) begin errors++; $display("FAIL mid_status: cnt %0d drop %b done %b want 0 0 0", xfer_cnt, drop_err, xfer_done); end
        step();
        reset = 1'b0;
        sum_in = 24'h00BEEF; sum_valid = 1'b1;
        step(); sum_valid = 1'b0;
        checks++; if (tx_req !== 1'b1 || tx_data !== 24'h00BEEF) begin errors++; $display("FAIL mid_relaunch: req %b data %h want 1 00beef", tx_req, tx_data); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_relaunch_busy: got %b want 1", busy); end
    endtask

    // Randomised run: a delayed-ack peer, a ready-gated source and a
    // scoreboard of accepted versus received sums over 256 transfers.
    task automatic test_wrap_random();
        logic [23:0] sent_q[$];
        logic [23:0] recv_q[$];
        bit          armed;
        int          dly;
        logic        pipe0, pipe1, pipe2, exp_done;
        int          exp_cnt;
        logic [23:0] prev_data;
        logic        prev_req;
        int          cyc;
        int          bad;
        do_reset();
        armed = 1'b0; dly = 0; pipe0 = 1'b0; pipe1 = 1'b0; pipe2 = 1'b0;
        exp_cnt = 0; cyc = 0;
        prev_data = tx_data; prev_req = tx_req;
        while (exp_cnt < 256 && cyc < 20000) begin
            step();
            cyc++;
            exp_done = pipe0; pipe0 = pipe1; pipe1 = pipe2; pipe2 = 1'b0;
            if (exp_done) exp_cnt++;
            checks++; if (xfer_done !== exp_done) begin errors++; $display("FAIL rnd_done cyc %0d: got %b want %b", cyc, xfer_done, exp_done); end
            checks++; if (xfer_cnt !== 8'(exp_cnt)) begin errors++; $display("FAIL rnd_cnt cyc %0d: got %0d want %0d", cyc, xfer_cnt, 8'(exp_cnt)); end
            checks++; if (tx_data !== prev_data && tx_req === prev_req) begin errors++; $display("FAIL rnd_stable cyc %0d: data %h changed without req toggle", cyc, tx_data); end
            checks++; if (tx_req !== prev_req && rx_ack !== prev_req) begin errors++; $display("FAIL rnd_early_toggle cyc %0d: req %b before ack %b", cyc, tx_req, rx_ack); end
            prev_data = tx_data; prev_req = tx_req;
            if (!armed && tx_req !== rx_ack) begin
                armed = 1'b1;
                dly = $urandom_range(0, 10);
                recv_q.push_back(tx_data);
            end
            if (armed) begin
                if (dly == 0) begin
                    rx_ack = tx_req; armed = 1'b0; pipe2 = 1'b1;
                end else begin
                    dly--;
                end
            end
            if (sent_q.size() < 256 && sum_ready === 1'b1 && $urandom_range(0, 1) == 1) begin
                sum_in = 24'($urandom); sum_valid = 1'b1;
                sent_q.push_back(sum_in);
            end else begin
                sum_valid = 1'b0;
            end
        end
        sum_valid = 1'b0;
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rnd_timeout: completions %0d want 256", exp_cnt); end
        checks++; if (xfer_cnt !== 8'd0) begin errors++; $display("FAIL rnd_wrap: got %0d want 0", xfer_cnt); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL rnd_drop: got %b want 0", drop_err); end
        checks++; if (recv_q.size() != 256 || sent_q.size() != 256) begin errors++; $display("FAIL rnd_count: recv %0d sent %0d want 256", recv_q.size(), sent_q.size()); end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i < recv_q.size() && i < sent_q.size() && recv_q[i] !== sent_q[i]) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rnd_order: %0d entries differ, want 0", bad); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rnd_idle: busy got %b want 0", busy); end
    endtask

    initial begin
        reset = 1'b1; sum_in = 24'h0; sum_valid = 1'b0; rx_ack = 1'b0;
        test_reset();
        test_single();
        test_buffered();
        test_drop();
        test_drop_on_completion();
        test_same_cycle();
        test_reset_mid();
        test_wrap_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
